register_file: RTL and testbench



---
 rtl/register_file.sv | 84 ++++++++
 tb/tb_register_file.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/register_file.sv
// Bank of DATA_DEPTH configuration registers. Async active-low load from regi_i, bus writes gated by mode_mask_i.
// Optional REGFILE_WR_ERR_EN adds a registered one-cycle pulse wr_err_o for each rejected write.
module register_file #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DATA_DEPTH = 64,
  parameter int unsigned ADDR_W     = (DATA_DEPTH > 1) ? $clog2(DATA_DEPTH) : 1
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  write_en_i,
  input  logic                                  read_en_i,
  input  logic [ADDR_W-1:0]                     addr_i,
  input  logic [DATA_WIDTH-1:0]                 write_data_i,
  output logic [DATA_WIDTH-1:0]                 read_data_o,
`ifdef REGFILE_WR_ERR_EN
  output logic                                  wr_err_o,
`endif
  input  logic [DATA_DEPTH-1:0][DATA_WIDTH-1:0] regi_i,
  input  logic [DATA_DEPTH-1:0]                 mode_mask_i,
  output logic [DATA_DEPTH-1:0][DATA_WIDTH-1:0] rego_o
);

  logic [DATA_DEPTH-1:0][DATA_WIDTH-1:0] regs_q, regs_d;
  logic                                  addr_valid;
  logic                                  addr_ro;
  logic                                  wr_ok;

  // Range check is only needed when the address space has unused codes.
  if (DATA_DEPTH == (2 ** ADDR_W)) begin : g_full_range
    assign addr_valid = 1'b1;
  end else begin : g_part_range
    assign addr_valid = (32'(addr_i) < DATA_DEPTH);
  end

  always_comb begin
    addr_ro = 1'b0;
    if (addr_valid) begin
      addr_ro = mode_mask_i[addr_i];
    end
  end

  assign wr_ok = write_en_i && addr_valid && !addr_ro;

  always_comb begin
    regs_d = regs_q;
    if (wr_ok) begin
      regs_d[addr_i] = write_data_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs_q <= regi_i;
    end else begin
      regs_q <= regs_d;
    end
  end

  always_comb begin
    read_data_o = '0;
    if (read_en_i && addr_valid) begin
      read_data_o = regs_q[addr_i];
    end
  end

  assign rego_o = regs_q;

`ifdef REGFILE_WR_ERR_EN
  logic wr_err_q, wr_err_d;

  assign wr_err_d = write_en_i && (!addr_valid || addr_ro);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_err_q <= 1'b0;
    end else begin
      wr_err_q <= wr_err_d;
    end
  end

  assign wr_err_o = wr_err_q;
`endif

endmodule

// File: tb/tb_register_file.sv
// Directed self-checking bench for register_file (default 8 x 64 configuration).
module tb_register_file;
  localparam int unsigned DW   = 8;
  localparam int unsigned DD   = 64;
  localparam int unsigned AW   = 6;
  localparam int unsigned BAUD = 20;

  logic                  clk;
  logic                  rst_n;
  logic                  write_en;
  logic                  read_en;
  logic [AW-1:0]         addr;
  logic [DW-1:0]         write_data;
  logic [DW-1:0]         read_data;
  logic [DD-1:0][DW-1:0] regi;
  logic [DD-1:0]         mode_mask;
  logic [DD-1:0][DW-1:0] rego;
`ifdef REGFILE_WR_ERR_EN
  logic                  wr_err;
`endif

  int errors = 0;
  int checks = 0;

  register_file #(.DATA_WIDTH(DW), .DATA_DEPTH(DD)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .write_en_i   (write_en),
    .read_en_i    (read_en),
    .addr_i       (addr),
    .write_data_i (write_data),
    .read_data_o  (read_data),
`ifdef REGFILE_WR_ERR_EN
    .wr_err_o     (wr_err),
`endif
    .regi_i       (regi),
    .mode_mask_i  (mode_mask),
    .rego_o       (rego)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    @(negedge clk);
    write_en   = 1'b1;
    addr       = a;
    write_data = d;
    @(posedge clk);
    #1;
    write_en = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [AW-1:0] a, input logic [DW-1:0] exp);
    read_en = 1'b1;
    addr    = a;
    #1;
    check(tag, read_data, exp);
  endtask

  initial begin
    logic [DW-1:0] exp_v;
    rst_n      = 1'b1;
    write_en   = 1'b0;
    read_en    = 1'b0;
    addr       = '0;
    write_data = '0;
    regi       = '0;
    regi[0]    = 8'hAA;
    regi[BAUD] = 8'h30;
    mode_mask  = '0;
    mode_mask[0]    = 1'b1;
    mode_mask[BAUD] = 1'b1;

    // Reset state
    #2 rst_n = 1'b0;
    #1;
    check("rst_rego0", rego[0], 8'hAA);
    check("rst_rego20", rego[BAUD], 8'h30);
    rd("rst_rd0", 6'd0, 8'hAA);
    rd("rst_rd5", 6'd5, 8'h00);
`ifdef REGFILE_WR_ERR_EN
    check("rst_wr_err", {7'd0, wr_err}, 8'h00);
`endif
    @(negedge clk);
    rst_n   = 1'b1;
    read_en = 1'b0;

    // Write i to every address, then read all back
    for (int i = 0; i < int'(DD); i++) begin
      do_write(AW'(i), DW'(i));
    end
    for (int i = 0; i < int'(DD); i++) begin
      if (i == 0) exp_v = 8'hAA;
      else if (i == int'(BAUD)) exp_v = 8'h30;
      else exp_v = DW'(i);
      rd($sformatf("rdback_%0d", i), AW'(i), exp_v);
      check($sformatf("rego_%0d", i), rego[i], exp_v);
    end

    // read_en low forces zero
    read_en = 1'b0;
    addr    = 6'd3;
    #1 check("rden0_a3", read_data, 8'h00);
    addr    = 6'd63;
    #1 check("rden0_a63", read_data, 8'h00);
    rd("rden1_a3", 6'd3, 8'h03);

    // Simultaneous read/write: old value until the edge, then new
    @(negedge clk);
    write_en   = 1'b1;
    read_en    = 1'b1;
    addr       = 6'd12;
    write_data = 8'hC3;
    #1 check("rw_before", read_data, 8'h0C);
    @(posedge clk);
    #1 check("rw_after", read_data, 8'hC3);
    write_en = 1'b0;
    check("rw_rego12", rego[12], 8'hC3);

    // Write 0x55 to 10, then reset mid-cycle with another write pending
    do_write(6'd10, 8'h55);
    rd("wr10", 6'd10, 8'h55);
    @(negedge clk);
    write_en   = 1'b1;
    addr       = 6'd11;
    write_data = 8'h77;
    #2 rst_n = 1'b0;
    #1;
    check("midrst_rego10", rego[10], 8'h00);
    check("midrst_rego12", rego[12], 8'h00);
    check("midrst_rego0", rego[0], 8'hAA);
    @(posedge clk);
    #1;
    write_en = 1'b0;
    check("midrst_lost11", rego[11], 8'h00);
    rd("midrst_rd10", 6'd10, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;

    // regi changes after reset are ignored
    regi[5] = 8'hEE;
    regi[0] = 8'h11;
    @(posedge clk);
    #1;
    rd("regichg_rd5", 6'd5, 8'h00);
    check("regichg_rego0", rego[0], 8'hAA);
    do_write(6'd5, 8'h5A);
    rd("after_regichg_wr5", 6'd5, 8'h5A);
    do_write(6'd0, 8'hFF);
    rd("masked_wr0", 6'd0, 8'hAA);

`ifdef REGFILE_WR_ERR_EN
    // Rejected write pulses wr_err for one cycle
    @(negedge clk);
    write_en   = 1'b1;
    addr       = 6'd0;
    write_data = 8'h42;
    @(posedge clk);
    #1;
    write_en = 1'b0;
    check("wr_err_pulse", {7'd0, wr_err}, 8'h01);
    @(posedge clk);
    #1 check("wr_err_clear", {7'd0, wr_err}, 8'h00);
    rd("wr_err_reg0", 6'd0, 8'hAA);
    do_write(6'd6, 8'h66);
    check("wr_err_ok", {7'd0, wr_err}, 8'h00);
    rd("wr_err_rd6", 6'd6, 8'h66);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
